// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant covers one burst: up to BURST_LEN beats, or fewer if the producer flags last.
module fifo_write_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int W_DATA_WIDTH = 64,
    parameter int BURST_LEN    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*W_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            full_flag,
    output logic                            fifo_write_request,
    output logic [W_DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                                  state, state_nx;
    logic [IDX_W-1:0]                        grant_idx, grant_idx_nx;
    logic [IDX_W-1:0]                        rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0]                        pick_idx, cand;
    logic [CNT_W-1:0]                        beat_cnt, beat_cnt_nx;
    logic [NUM_REQ-1:0]                      grant_nx;
    logic [NUM_REQ-1:0][W_DATA_WIDTH-1:0]    slot;
    logic                                    pick_found, accept, burst_end;

    assign slot = req_data;

    // Scan downward so the last hit is the closest requester at/after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy      = (state == BURST);
    assign accept    = busy & req_valid[grant_idx] & ~full_flag;
    assign burst_end = accept & (req_last[grant_idx] | (beat_cnt == CNT_W'(BURST_LEN - 1)));

    always_comb begin
        req_ready = '0;
        if (busy && !full_flag) req_ready[grant_idx] = 1'b1;
    end

    assign fifo_write_request = accept;
    assign fifo_wr_data       = busy ? slot[grant_idx] : '0;

    always_comb begin
        state_nx     = state;
        grant_idx_nx = grant_idx;
        grant_nx     = grant;
        beat_cnt_nx  = beat_cnt;
        rr_ptr_nx    = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx     = BURST;
                    grant_idx_nx = pick_idx;
                    grant_nx     = NUM_REQ'(1) << pick_idx;
                    beat_cnt_nx  = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_nx    = IDLE;
                    grant_nx    = '0;
                    beat_cnt_nx = '0;
                    rr_ptr_nx   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                end else if (accept) begin
                    beat_cnt_nx = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nx;
            grant_idx <= grant_idx_nx;
            grant     <= grant_nx;
            beat_cnt  <= beat_cnt_nx;
            rr_ptr    <= rr_ptr_nx;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: a burst-level model predicts grant/ready/writes per cycle;
// a negedge monitor compares the DUT against the queued expectations.
module tb_fifo_write_arbiter;
    localparam int N  = 3;
    localparam int W  = 64;
    localparam int BL = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_last, req_ready, grant;
    logic [N*W-1:0]   req_data;
    logic             full_flag, fifo_write_request, busy;
    logic [W-1:0]     fifo_wr_data;

    fifo_write_arbiter #(.NUM_REQ(N), .W_DATA_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .full_flag(full_flag),
        .fifo_write_request(fifo_write_request), .fifo_wr_data(fifo_wr_data),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] ready;
        logic         wr;
    } exp_t;

    exp_t         cyc_q[$];
    logic [W-1:0] wr_q[$];
    int checks = 0;
    int fails  = 0;

    // model state: owner is the producer holding the port (-1 when nobody)
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int seq[N];
    int last_at[N];
    bit auto_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        return {16'(i), 48'(seq[i])};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic f, input logic r);
        exp_t e;
        int   o;
        bit   acc, lastw, found;
        reset     = r;
        full_flag = f;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = word_of(i);
            req_last[i]        = (seq[i] == last_at[i]);
        end
        o = m_owner;
        e = '0;
        acc = 1'b0;
        lastw = 1'b0;
        if (o >= 0) begin
            e.grant[o] = 1'b1;
            e.ready[o] = !f;
            acc = v[o] && !f;
            e.wr = acc;
        end
        cyc_q.push_back(e);
        if (acc) begin
            wr_q.push_back(word_of(o));
            lastw = (seq[o] == last_at[o]);
            seq[o]++;
            if (lastw) last_at[o] = auto_last ? seq[o] + int'($urandom_range(0, 5)) : 32'h7fff_ffff;
            m_beats++;
        end
        if (r) begin
            m_owner = -1; m_ptr = 0; m_beats = 0;
        end else if (o < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++)
                if (!found && v[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            m_beats = 0;
        end else if (acc && (lastw || m_beats == BL)) begin
            m_ptr   = (o + 1) % N;
            m_owner = -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("grant", 64'(grant), 64'(e.grant));
                chk("req_ready", 64'(req_ready), 64'(e.ready));
                chk("write_request", 64'(fifo_write_request), 64'(e.wr));
                chk("busy", 64'(busy), 64'(e.grant != '0));
                if (e.grant == '0) chk("idle_wr_data", fifo_wr_data, 64'h0);
                if (fifo_write_request) begin
                    if (wr_q.size() == 0) chk("spurious_write", 64'h1, 64'h0);
                    else chk("wr_data", fifo_wr_data, wr_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = 1;
            last_at[i] = 32'h7fff_ffff;
        end
        reset = 1'b1; full_flag = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
        @(posedge clk);
        #1;
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);

        // single producer: six words, last on the sixth, split 4 + 2
        last_at[0] = 6;
        repeat (8) step(3'b001, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b0, 1'b0);

        // round robin with everyone continuously valid
        repeat (16) step(3'b111, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b0, 1'b0);

        // backpressure: full for three cycles after the first beat
        step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        repeat (3) step(3'b010, 1'b1, 1'b0);
        repeat (4) step(3'b010, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b0, 1'b0);

        // early last from producer 2, pointer wraps to 0
        last_at[2] = seq[2];
        repeat (3) step(3'b100, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);

        // stall: owner drops valid for five cycles while producer 1 waits
        step(3'b011, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b0);
        repeat (5) step(3'b010, 1'b0, 1'b0);
        repeat (4) step(3'b011, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b0, 1'b0);

        // reset after the second beat of producer 1
        repeat (3) step(3'b010, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b1);
        repeat (3) step(3'b011, 1'b0, 1'b0);
        repeat (4) step(3'b000, 1'b0, 1'b0);

        // randomized traffic, backpressure and occasional reset
        auto_last = 1'b1;
        for (int i = 0; i < N; i++) last_at[i] = seq[i] + int'($urandom_range(0, 5));
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
            step(v, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (6) step(3'b000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("pending_writes", 64'(wr_q.size()), 64'h0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
